// File: rtl/pf_lanectrl_dly_pkg.sv
// Shared definitions for the lane delay-line step sequencer: op codes, FSM states, lane-index width.
package pf_lanectrl_dly_pkg;

  localparam logic OP_MOVE = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACT,
    ST_POST,
    ST_DONE
  } state_t;

  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pf_lanectrl_dly_seq_if.sv
// Request handshake plus per-lane LANECTRL delay-line/pause bundle.
// slave = sequencer view, master = requester/lane-model view.
interface pf_lanectrl_dly_seq_if #(
  parameter int NUM_LANES = 4,
  parameter int TAP_W     = 8,
  parameter int LANE_W    = pf_lanectrl_dly_pkg::lane_w(NUM_LANES)
);
  logic                       REQ_VALID;
  logic                       REQ_READY;
  logic [LANE_W-1:0]          REQ_LANE;
  logic                       REQ_OP;
  logic                       REQ_DIR;
  logic [TAP_W-1:0]           REQ_STEPS;
  logic                       DONE;
  logic                       DONE_ERR;
  logic [NUM_LANES-1:0]       HS_IO_CLK_PAUSE;
  logic [NUM_LANES-1:0]       DELAY_LINE_MOVE;
  logic [NUM_LANES-1:0]       DELAY_LINE_LOAD;
  logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION;
  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE;
  logic [NUM_LANES*TAP_W-1:0] TAP_COUNT;

  modport slave (
    input  REQ_VALID, REQ_LANE, REQ_OP, REQ_DIR, REQ_STEPS, DELAY_LINE_OUT_OF_RANGE,
    output REQ_READY, DONE, DONE_ERR, HS_IO_CLK_PAUSE, DELAY_LINE_MOVE,
           DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, TAP_COUNT
  );

  modport master (
    output REQ_VALID, REQ_LANE, REQ_OP, REQ_DIR, REQ_STEPS, DELAY_LINE_OUT_OF_RANGE,
    input  REQ_READY, DONE, DONE_ERR, HS_IO_CLK_PAUSE, DELAY_LINE_MOVE,
           DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, TAP_COUNT
  );

endinterface

// File: rtl/pf_lanectrl_tap_cnt.sv
// Shadow tap counter for one lane; updates on the edge of the move/load it tracks.
// Saturates at 0 and MAX_TAP; load and reset both restore LOAD_TAP.
module pf_lanectrl_tap_cnt #(
  parameter int TAP_W    = 8,
  parameter int MAX_TAP  = 255,
  parameter int LOAD_TAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  output logic [TAP_W-1:0] count,
  output logic             at_min,
  output logic             at_max
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= TAP_W'(LOAD_TAP);
    end else if (inc && !at_max) begin
      count <= count + TAP_W'(1);
    end else if (dec && !at_min) begin
      count <= count - TAP_W'(1);
    end
  end

  assign at_min = (count == '0);
  assign at_max = (count == TAP_W'(MAX_TAP));

endmodule

// File: rtl/pf_lanectrl_dly_seq.sv
// Sequences one tap-adjust request at a time: pause window, paced move/load pulses, shadow taps.
// All outputs registered; REQ_READY only in idle, DONE lands PRE+2N+POST+1 cycles after accept.
module pf_lanectrl_dly_seq
  import pf_lanectrl_dly_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int LOAD_TAP   = 1,
  parameter int PAUSE_PRE  = 2,
  parameter int PAUSE_POST = 2
) (
  input  logic                 FAB_CLK,
  input  logic                 RESET,
  pf_lanectrl_dly_seq_if.slave bus
);

  localparam int LANE_W = lane_w(NUM_LANES);
  localparam int TMR_W  = $clog2(((PAUSE_PRE > PAUSE_POST) ? PAUSE_PRE : PAUSE_POST) + 1);

  state_t               state;
  logic [LANE_W-1:0]    lane_q;
  logic                 op_q, dir_q, err_q, phase_q, oor_q;
  logic [TAP_W-1:0]     steps_q;
  logic [TMR_W-1:0]     timer_q;
  logic                 ready_q, done_q, done_err_q;
  logic [NUM_LANES-1:0] pause_q, move_q, load_q, dirn_q;
  logic [NUM_LANES-1:0] lane_oh, at_min_v, at_max_v;
  logic [TAP_W-1:0]     taps [NUM_LANES];
  logic                 accept, lane_bad, blocked, step_go, load_go;

  always_comb begin
    accept   = bus.REQ_VALID && ready_q;
    lane_bad = int'(bus.REQ_LANE) >= NUM_LANES;
    lane_oh  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_oh[i] = (int'(lane_q) == i);
    end
    // oor_q is last cycle's range flag, so a flag raised with a pulse stops the next one
    blocked = oor_q || (dir_q ? |(at_max_v & lane_oh) : |(at_min_v & lane_oh));
    step_go = (state == ST_ACT) && (op_q == OP_MOVE) && !phase_q && !blocked;
    load_go = (state == ST_ACT) && (op_q == OP_LOAD);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap
    pf_lanectrl_tap_cnt #(
      .TAP_W   (TAP_W),
      .MAX_TAP (MAX_TAP),
      .LOAD_TAP(LOAD_TAP)
    ) u_tap (
      .clk   (FAB_CLK),
      .rst   (RESET),
      .inc   (lane_oh[g] && step_go && dir_q),
      .dec   (lane_oh[g] && step_go && !dir_q),
      .load  (lane_oh[g] && load_go),
      .count (taps[g]),
      .at_min(at_min_v[g]),
      .at_max(at_max_v[g])
    );
    assign bus.TAP_COUNT[g*TAP_W +: TAP_W] = taps[g];
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      lane_q     <= '0;
      op_q       <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      phase_q    <= 1'b0;
      oor_q      <= 1'b0;
      steps_q    <= '0;
      timer_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      pause_q    <= '0;
      move_q     <= '0;
      load_q     <= '0;
      dirn_q     <= '0;
    end else begin
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      move_q     <= '0;
      load_q     <= '0;
      oor_q      <= |(bus.DELAY_LINE_OUT_OF_RANGE & lane_oh);
      case (state)
        ST_IDLE: begin
          ready_q <= !accept;
          pause_q <= '0;
          dirn_q  <= '0;
          if (accept) begin
            lane_q  <= bus.REQ_LANE;
            op_q    <= bus.REQ_OP;
            dir_q   <= bus.REQ_DIR;
            steps_q <= bus.REQ_STEPS;
            err_q   <= lane_bad;
            if (lane_bad || (bus.REQ_OP == OP_MOVE && bus.REQ_STEPS == '0)) begin
              state <= ST_DONE;
            end else begin
              timer_q <= TMR_W'(PAUSE_PRE - 1);
              state   <= ST_PRE;
            end
          end
        end
        ST_PRE: begin
          pause_q <= lane_oh;
          dirn_q  <= dir_q ? lane_oh : '0;
          if (timer_q == '0) begin
            phase_q <= 1'b0;
            state   <= ST_ACT;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_ACT: begin
          if (op_q == OP_LOAD) begin
            load_q  <= lane_oh;
            timer_q <= TMR_W'(PAUSE_POST - 1);
            state   <= ST_POST;
          end else if (phase_q) begin
            if (steps_q == '0) begin
              timer_q <= TMR_W'(PAUSE_POST - 1);
              state   <= ST_POST;
            end else begin
              phase_q <= 1'b0;
            end
          end else if (blocked) begin
            // the suppressed pulse slot already counts as the first POST cycle
            err_q <= 1'b1;
            if (PAUSE_POST == 1) begin
              state <= ST_DONE;
            end else begin
              timer_q <= TMR_W'(PAUSE_POST - 2);
              state   <= ST_POST;
            end
          end else begin
            move_q  <= lane_oh;
            steps_q <= steps_q - TAP_W'(1);
            phase_q <= 1'b1;
          end
        end
        ST_POST: begin
          if (timer_q == '0) begin
            state <= ST_DONE;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_DONE: begin
          done_q     <= 1'b1;
          done_err_q <= err_q;
          pause_q    <= '0;
          dirn_q     <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.REQ_READY            = ready_q;
  assign bus.DONE                 = done_q;
  assign bus.DONE_ERR             = done_err_q;
  assign bus.HS_IO_CLK_PAUSE      = pause_q;
  assign bus.DELAY_LINE_MOVE      = move_q;
  assign bus.DELAY_LINE_LOAD      = load_q;
  assign bus.DELAY_LINE_DIRECTION = dirn_q;

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// Scoreboard bench: stimulus pushes hand-computed outcomes, a negedge monitor checks each DONE.
// Five lanes so the 3-bit lane field can carry out-of-range indices 5 and 7.
module tb_pf_lanectrl_dly_seq;

  localparam int NL = 5;
  localparam int TW = 8;
  localparam int LW = 3;

  typedef struct {
    int id;
    int lane;
    int err;
    int done_cyc;
    int moves;
    int loads;
    int pause;
    int dircyc;
    int first_cyc;
    int first_tap;
    int tap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   req_id = 0;
  exp_t sb_q[$];

  int   mv[NL], ld[NL], pz[NL], dc[NL], fc[NL], ft[NL];
  bit   rdy_chk;

  pf_lanectrl_dly_seq_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();

  pf_lanectrl_dly_seq #(.NUM_LANES(NL), .TAP_W(TW)) dut (
    .FAB_CLK(clk),
    .RESET  (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input int act, input int exp_v);
    n_assert++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic int tap_of(input int l);
    return int'(bus.TAP_COUNT[l*TW +: TW]);
  endfunction

  // Issue one request; outcome fields are relative to the accept edge t0.
  task automatic issue(input int lane, input int op, input int dir, input int steps,
                       input int err, input int lat, input int moves, input int loads,
                       input int pause, input int dircyc, input int first, input int first_tap,
                       input int tap);
    exp_t e;
    int   budget;
    budget = 0;
    @(negedge clk);
    while (!bus.REQ_READY && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.REQ_READY) begin
      check($sformatf("req%0d_ready_timeout", req_id), 0, 1);
      return;
    end
    bus.REQ_LANE  = LW'(lane);
    bus.REQ_OP    = op[0];
    bus.REQ_DIR   = dir[0];
    bus.REQ_STEPS = TW'(steps);
    bus.REQ_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    check($sformatf("req%0d_ready_drop", req_id), int'(bus.REQ_READY), 0);
    e.id        = req_id;
    e.lane      = lane;
    e.err       = err;
    e.done_cyc  = cyc + lat;
    e.moves     = moves;
    e.loads     = loads;
    e.pause     = pause;
    e.dircyc    = dircyc;
    e.first_cyc = (first < 0) ? -1 : cyc + first;
    e.first_tap = first_tap;
    e.tap       = tap;
    sb_q.push_back(e);
    req_id++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        mv[i] = 0; ld[i] = 0; pz[i] = 0; dc[i] = 0; fc[i] = -1; ft[i] = -1;
      end
      rdy_chk = 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        mv[i] += int'(bus.DELAY_LINE_MOVE[i]);
        ld[i] += int'(bus.DELAY_LINE_LOAD[i]);
        pz[i] += int'(bus.HS_IO_CLK_PAUSE[i]);
        dc[i] += int'(bus.DELAY_LINE_DIRECTION[i]);
        if (fc[i] < 0 && (bus.DELAY_LINE_MOVE[i] || bus.DELAY_LINE_LOAD[i])) begin
          fc[i] = cyc;
          ft[i] = tap_of(i);
        end
      end
      if (rdy_chk) begin
        check("ready_after_done", int'(bus.REQ_READY), 1);
        rdy_chk = 1'b0;
      end
      if (bus.DONE) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          int   own, total;
          e = sb_q.pop_front();
          check($sformatf("req%0d_done_cyc", e.id), cyc, e.done_cyc);
          check($sformatf("req%0d_done_err", e.id), int'(bus.DONE_ERR), e.err);
          total = 0;
          for (int i = 0; i < NL; i++) total += mv[i] + ld[i] + pz[i] + dc[i];
          own = 0;
          if (e.lane < NL) begin
            own = mv[e.lane] + ld[e.lane] + pz[e.lane] + dc[e.lane];
            check($sformatf("req%0d_moves", e.id), mv[e.lane], e.moves);
            check($sformatf("req%0d_loads", e.id), ld[e.lane], e.loads);
            check($sformatf("req%0d_pause_cycles", e.id), pz[e.lane], e.pause);
            check($sformatf("req%0d_dir_cycles", e.id), dc[e.lane], e.dircyc);
            check($sformatf("req%0d_first_pulse_cyc", e.id), fc[e.lane], e.first_cyc);
            if (e.first_tap >= 0)
              check($sformatf("req%0d_tap_at_pulse", e.id), ft[e.lane], e.first_tap);
            check($sformatf("req%0d_tap_final", e.id), tap_of(e.lane), e.tap);
          end
          check($sformatf("req%0d_other_lane_activity", e.id), total - own, 0);
        end
        for (int i = 0; i < NL; i++) begin
          mv[i] = 0; ld[i] = 0; pz[i] = 0; dc[i] = 0; fc[i] = -1; ft[i] = -1;
        end
        rdy_chk = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    bus.REQ_VALID = 1'b0;
    bus.REQ_LANE  = '0;
    bus.REQ_OP    = 1'b0;
    bus.REQ_DIR   = 1'b0;
    bus.REQ_STEPS = '0;
    bus.DELAY_LINE_OUT_OF_RANGE = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.REQ_READY), 0);
    check("rst_done", int'(bus.DONE), 0);
    check("rst_done_err", int'(bus.DONE_ERR), 0);
    check("rst_pause", int'(bus.HS_IO_CLK_PAUSE), 0);
    check("rst_move", int'(bus.DELAY_LINE_MOVE), 0);
    check("rst_load", int'(bus.DELAY_LINE_LOAD), 0);
    check("rst_dir", int'(bus.DELAY_LINE_DIRECTION), 0);
    for (int l = 0; l < NL; l++) check($sformatf("rst_tap%0d", l), tap_of(l), 1);
    rst = 1'b0;
    @(negedge clk);
    check("ready_first_edge", int'(bus.REQ_READY), 1);

    //    lane op dir steps err lat moves loads pause dircyc first ftap tap
    issue(2,   0, 1,  3,    0,  11, 3,    0,    10,   10,    3,    2,   4);
    issue(0,   0, 1,  2,    0,  9,  2,    0,    8,    8,     3,    2,   3);
    issue(0,   1, 0,  0,    0,  6,  0,    1,    5,    0,     3,    1,   1);
    issue(1,   0, 0,  5,    1,  7,  1,    0,    6,    0,     3,    0,   0);
    issue(3,   0, 1,  5,    1,  9,  2,    0,    8,    8,     3,    2,   3);
    repeat (5) @(negedge clk);
    bus.DELAY_LINE_OUT_OF_RANGE[3] = 1'b1;
    repeat (6) @(negedge clk);
    bus.DELAY_LINE_OUT_OF_RANGE[3] = 1'b0;
    issue(3,   0, 1,  255,  1,  509, 252, 0,    508,  508,   3,    4,   255);
    issue(5,   0, 1,  3,    1,  1,  0,    0,    0,    0,     -1,   -1,  -1);
    issue(7,   1, 0,  0,    1,  1,  0,    0,    0,    0,     -1,   -1,  -1);
    issue(2,   0, 1,  0,    0,  1,  0,    0,    0,    0,     -1,   -1,  4);
    issue(4,   0, 1,  1,    0,  7,  1,    0,    6,    6,     3,    2,   2);

    // Reset in the middle of a move on lane 0: no DONE, taps restored.
    budget = 0;
    @(negedge clk);
    while (!bus.REQ_READY && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check("rstmid_ready_wait", int'(bus.REQ_READY), 1);
    bus.REQ_LANE  = 3'd0;
    bus.REQ_OP    = 1'b0;
    bus.REQ_DIR   = 1'b1;
    bus.REQ_STEPS = 8'd3;
    bus.REQ_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_in_act_move", int'(bus.DELAY_LINE_MOVE), 1);
    check("rstmid_tap0_moved", tap_of(0), 2);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_pause", int'(bus.HS_IO_CLK_PAUSE), 0);
    check("rstmid_dir", int'(bus.DELAY_LINE_DIRECTION), 0);
    check("rstmid_move", int'(bus.DELAY_LINE_MOVE), 0);
    check("rstmid_done", int'(bus.DONE), 0);
    check("rstmid_ready", int'(bus.REQ_READY), 0);
    for (int l = 0; l < NL; l++) check($sformatf("rstmid_tap%0d", l), tap_of(l), 1);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_after_release", int'(bus.REQ_READY), 1);
    repeat (20) @(negedge clk);
    check("rstmid_no_done", int'(bus.DONE), 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
